// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/host arbiter for the shared single-port data memory
module dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 9,
  parameter int MAX_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_SHARE  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_RUN);

  state_e            state_q;
  logic              locked_q;
  logic              rr_last_q;   // 1 = host was granted last
  logic              rr_last_d;
  logic [3:0]        run_cnt_q;
  logic [3:0]        run_cnt_d;
  logic              rd_cpu_q;
  logic              rd_host_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic gnt_cpu;
  logic gnt_host;
  logic run_open;
  logic host_wins_tie;
  logic cpu_vld;
  logic host_vld;

  // A run of 0 means no run is in progress, so the tie goes to the port that was not last
  assign run_open      = (run_cnt_q != 4'd0) && (run_cnt_q < RUN_LIMIT);
  assign host_wins_tie = run_open ? rr_last_q : !rr_last_q;

  // Grant selection from registered state; nothing is granted while in reset
  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_host = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_SHARE: begin
          if (cpu_req && host_req) begin
            gnt_host = host_wins_tie;
            gnt_cpu  = !host_wins_tie;
          end else begin
            gnt_cpu  = cpu_req;
            gnt_host = host_req;
          end
        end
        ST_LOCKED: gnt_host = host_req;
        default: ;
      endcase
    end
  end

  // Memory strobes follow the granted requester in the same cycle
  always_comb begin
    mem_en    = gnt_cpu || gnt_host;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_cpu) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt_host) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Round-robin bookkeeping; leaving the lock hands the next tie to the stalled CPU
  always_comb begin
    rr_last_d = rr_last_q;
    run_cnt_d = run_cnt_q;
    if (state_q == ST_LOCKED && !host_lock) begin
      rr_last_d = 1'b1;
      run_cnt_d = 4'd0;
    end else if (state_q == ST_SHARE && (gnt_cpu || gnt_host)) begin
      if (gnt_host == rr_last_q) begin
        run_cnt_d = (run_cnt_q < RUN_LIMIT) ? run_cnt_q + 4'd1 : run_cnt_q;
      end else begin
        rr_last_d = gnt_host;
        run_cnt_d = 4'd1;
      end
    end
  end

  // Round-robin state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b1;
      run_cnt_q <= 4'd0;
    end else begin
      rr_last_q <= rr_last_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Lock FSM: one DRAIN cycle lets an in-flight read return before the host takes over
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SHARE;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        ST_SHARE: begin
          if (host_lock) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (host_lock) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
          end else begin
            state_q  <= ST_SHARE;
          end
        end
        ST_LOCKED: begin
          if (!host_lock) begin
            state_q  <= ST_SHARE;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_SHARE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // Read return: remember who owns the read and keep each port's last data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cpu_q     <= 1'b0;
      rd_host_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      rd_cpu_q  <= gnt_cpu && !cpu_we;
      rd_host_q <= gnt_host && !host_we;
      if (rd_cpu_q)  cpu_rdata_q  <= mem_rdata;
      if (rd_host_q) host_rdata_q <= mem_rdata;
    end
  end

  // A read pending across a reset is dropped rather than delivered
  assign cpu_vld  = rd_cpu_q && !rst;
  assign host_vld = rd_host_q && !rst;

  assign cpu_gnt     = gnt_cpu;
  assign host_gnt    = gnt_host;
  assign cpu_rvalid  = cpu_vld;
  assign host_rvalid = host_vld;
  assign cpu_rdata   = cpu_vld ? mem_rdata : cpu_rdata_q;
  assign host_rdata  = host_vld ? mem_rdata : host_rdata_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int MAX_RUN = 4;
  localparam int W_CPU   = 0;
  localparam int W_HOST  = 1;
  localparam int W_NONE  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [8:0] cpu_wdata = '0;
  logic       cpu_gnt, cpu_rvalid;
  logic [8:0] cpu_rdata;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [8:0] host_wdata = '0;
  logic       host_gnt, host_rvalid;
  logic [8:0] host_rdata;
  logic       host_lock = 1'b0;
  logic       locked;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr;
  logic [8:0] mem_wdata;
  logic [8:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(9), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory the arbiter drives
  logic [8:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    host_lock = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [7:0] a, input logic [8:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [7:0] a, input logic [8:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected in that cycle
  typedef struct {
    logic       c_req, c_we;
    logic [7:0] c_addr;
    logic [8:0] c_wd;
    logic       h_req, h_we;
    logic [7:0] h_addr;
    logic [8:0] h_wd;
    logic       e_cg, e_hg, e_cv, e_hv;
    logic [8:0] e_cd, e_hd;
  } vec_t;

  vec_t vecs [11];

  // Reference arbitration: with both requesting, the last winner continues
  // until its trailing run of grants reaches MAX_RUN; no history means the CPU wins
  int hist [$];
  function automatic int tie_winner();
    int last, run;
    if (hist.size() == 0) return W_CPU;
    last = hist[hist.size()-1];
    run  = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) run++;
    if (run < MAX_RUN) return last;
    return (last == W_CPU) ? W_HOST : W_CPU;
  endfunction

  logic [8:0] shadow [0:255];

  initial begin
    int bad, hcount, w;
    logic       c_pend, h_pend, c_w, h_w;
    logic [7:0] c_a, h_a;
    logic [8:0] c_d, h_d;
    logic       e_cv, e_hv;
    logic [8:0] e_cd, e_hd;
    logic [7:0] e_addr;
    logic [8:0] e_wd;
    logic       e_we;

    vecs[0]  = '{1'b1,1'b1,8'h10,9'h041, 1'b0,1'b0,8'h00,9'h000, 1'b1,1'b0,1'b0,1'b0,9'h000,9'h000};
    vecs[1]  = '{1'b1,1'b0,8'h10,9'h000, 1'b0,1'b0,8'h00,9'h000, 1'b1,1'b0,1'b0,1'b0,9'h000,9'h000};
    vecs[2]  = '{1'b0,1'b0,8'h00,9'h000, 1'b1,1'b1,8'h20,9'h155, 1'b0,1'b1,1'b1,1'b0,9'h041,9'h000};
    vecs[3]  = '{1'b1,1'b0,8'h10,9'h000, 1'b1,1'b0,8'h20,9'h000, 1'b0,1'b1,1'b0,1'b0,9'h041,9'h000};
    vecs[4]  = '{1'b1,1'b0,8'h10,9'h000, 1'b0,1'b0,8'h00,9'h000, 1'b1,1'b0,1'b0,1'b1,9'h041,9'h155};
    vecs[5]  = '{1'b0,1'b0,8'h00,9'h000, 1'b1,1'b0,8'h10,9'h000, 1'b0,1'b1,1'b1,1'b0,9'h041,9'h155};
    vecs[6]  = '{1'b1,1'b0,8'h20,9'h000, 1'b0,1'b0,8'h00,9'h000, 1'b1,1'b0,1'b0,1'b1,9'h041,9'h041};
    vecs[7]  = '{1'b0,1'b0,8'h00,9'h000, 1'b1,1'b1,8'hFF,9'h1FF, 1'b0,1'b1,1'b1,1'b0,9'h155,9'h041};
    vecs[8]  = '{1'b1,1'b0,8'hFF,9'h000, 1'b0,1'b0,8'h00,9'h000, 1'b1,1'b0,1'b0,1'b0,9'h155,9'h041};
    vecs[9]  = '{1'b0,1'b0,8'h00,9'h000, 1'b0,1'b0,8'h00,9'h000, 1'b0,1'b0,1'b1,1'b0,9'h1FF,9'h041};
    vecs[10] = '{1'b0,1'b0,8'h00,9'h000, 1'b0,1'b0,8'h00,9'h000, 1'b0,1'b0,1'b0,1'b0,9'h1FF,9'h041};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_locked", locked, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    next_cycle();

    // Directed table: store/load, alternating ports, write-then-read of one address
    for (int i = 0; i < 11; i++) begin
      set_cpu(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wd);
      set_host(vecs[i].h_req, vecs[i].h_we, vecs[i].h_addr, vecs[i].h_wd);
      @(negedge clk);
      check($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
      check($sformatf("vec%0d_host_gnt", i), host_gnt, vecs[i].e_hg);
      check($sformatf("vec%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].e_cv);
      check($sformatf("vec%0d_host_rvalid", i), host_rvalid, vecs[i].e_hv);
      check($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_cd);
      check($sformatf("vec%0d_host_rdata", i), host_rdata, vecs[i].e_hd);
      check($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].e_cg | vecs[i].e_hg);
      if (vecs[i].e_cg) begin
        check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].c_addr);
        check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].c_we);
      end else if (vecs[i].e_hg) begin
        check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].h_addr);
        check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].h_we);
      end
      next_cycle();
    end
    idle();

    // Both requesting continuously: runs of MAX_RUN, CPU first
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_cpu(1'b1, 1'b0, 8'h10, 9'h0);
      set_host(1'b1, 1'b0, 8'h20, 9'h0);
      @(negedge clk);
      check($sformatf("rr%0d_cpu_gnt", i), cpu_gnt, ((i / MAX_RUN) % 2) == 0);
      check($sformatf("rr%0d_host_gnt", i), host_gnt, ((i / MAX_RUN) % 2) == 1);
      next_cycle();
    end

    // Lock request while a CPU read is in flight
    do_reset();
    set_cpu(1'b1, 1'b0, 8'h10, 9'h0);
    host_lock = 1'b1;
    @(negedge clk);
    check("lock_a_cpu_gnt", cpu_gnt, 1);
    check("lock_a_locked", locked, 0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 8'h00, 9'h0);
    set_host(1'b1, 1'b1, 8'h00, 9'h000);
    @(negedge clk);
    check("drain_cpu_rvalid", cpu_rvalid, 1);
    check("drain_cpu_rdata", cpu_rdata, 9'h041);
    check("drain_host_gnt", host_gnt, 0);
    check("drain_cpu_gnt", cpu_gnt, 0);
    check("drain_locked", locked, 0);
    next_cycle();
    bad = 0;
    hcount = 0;
    for (int i = 0; i < 256; i++) begin
      set_host(1'b1, 1'b1, 8'(i), 9'(i));
      set_cpu(1'b1, 1'b0, 8'h33, 9'h0);
      @(negedge clk);
      if (host_gnt === 1'b1) hcount++;
      if (!(host_gnt === 1'b1 && cpu_gnt === 1'b0 && locked === 1'b1 && mem_en === 1'b1 &&
            mem_we === 1'b1 && mem_addr === 8'(i) && mem_wdata === 9'(i))) bad++;
      next_cycle();
    end
    check("locked_write_stream_bad_cycles", bad, 0);
    check("locked_host_grants", hcount, 256);

    // Release with both requesting: host finishes this cycle, CPU first afterwards
    host_lock = 1'b0;
    set_host(1'b1, 1'b0, 8'h05, 9'h0);
    set_cpu(1'b1, 1'b0, 8'h07, 9'h0);
    @(negedge clk);
    check("rel_host_gnt", host_gnt, 1);
    check("rel_cpu_gnt", cpu_gnt, 0);
    check("rel_locked", locked, 1);
    next_cycle();
    set_host(1'b0, 1'b0, 8'h00, 9'h0);
    @(negedge clk);
    check("rel1_locked", locked, 0);
    check("rel1_cpu_gnt", cpu_gnt, 1);
    check("rel1_host_gnt", host_gnt, 0);
    check("rel1_host_rvalid", host_rvalid, 1);
    check("rel1_host_rdata", host_rdata, 9'h005);
    next_cycle();
    set_cpu(1'b0, 1'b0, 8'h00, 9'h0);
    @(negedge clk);
    check("rel2_cpu_rvalid", cpu_rvalid, 1);
    check("rel2_cpu_rdata", cpu_rdata, 9'h007);
    next_cycle();

    // Lock dropped during DRAIN: back to sharing, the held CPU request is served
    host_lock = 1'b1;
    @(negedge clk);
    next_cycle();
    host_lock = 1'b0;
    set_cpu(1'b1, 1'b0, 8'h09, 9'h0);
    @(negedge clk);
    check("abort_drain_cpu_gnt", cpu_gnt, 0);
    check("abort_drain_locked", locked, 0);
    next_cycle();
    @(negedge clk);
    check("abort_share_cpu_gnt", cpu_gnt, 1);
    next_cycle();
    set_cpu(1'b0, 1'b0, 8'h00, 9'h0);
    @(negedge clk);
    check("abort_cpu_rvalid", cpu_rvalid, 1);
    check("abort_cpu_rdata", cpu_rdata, 9'h009);
    next_cycle();

    // Reset the cycle after a host read grant
    set_host(1'b1, 1'b0, 8'h07, 9'h0);
    @(negedge clk);
    check("rstrd_host_gnt", host_gnt, 1);
    next_cycle();
    set_host(1'b0, 1'b0, 8'h00, 9'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_in_rst_host_rvalid", host_rvalid, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstrd_after_host_rvalid", host_rvalid, 0);
    check("rstrd_after_host_rdata", host_rdata, 0);
    check("rstrd_after_cpu_rdata", cpu_rdata, 0);
    check("rstrd_after_cpu_rvalid", cpu_rvalid, 0);
    check("rstrd_after_mem_en", mem_en, 0);
    check("rstrd_after_locked", locked, 0);
    next_cycle();

    // Reset while locked
    host_lock = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rstlk_locked_before", locked, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_cpu(1'b1, 1'b0, 8'h01, 9'h0);
    @(negedge clk);
    check("rstlk_locked_after", locked, 0);
    check("rstlk_cpu_gnt", cpu_gnt, 1);
    next_cycle();

    // Randomized traffic against the reference model; memory holds i at address i here
    do_reset();
    for (int i = 0; i < 256; i++) shadow[i] = 9'(i);
    hist.delete();
    c_pend = 1'b0; h_pend = 1'b0;
    c_w = 1'b0; h_w = 1'b0; c_a = '0; h_a = '0; c_d = '0; h_d = '0;
    e_cv = 1'b0; e_hv = 1'b0; e_cd = '0; e_hd = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (!c_pend && ($urandom % 100) < 60) begin
        c_pend = 1'b1; c_w = 1'($urandom % 2);
        c_a = 8'h80 + 8'($urandom % 16); c_d = 9'($urandom % 512);
      end
      if (!h_pend && ($urandom % 100) < 60) begin
        h_pend = 1'b1; h_w = 1'($urandom % 2);
        h_a = 8'h80 + 8'($urandom % 16); h_d = 9'($urandom % 512);
      end
      set_cpu(c_pend, c_w, c_a, c_d);
      set_host(h_pend, h_w, h_a, h_d);
      if (c_pend && h_pend) w = tie_winner();
      else if (c_pend)      w = W_CPU;
      else if (h_pend)      w = W_HOST;
      else                  w = W_NONE;
      @(negedge clk);
      check("rnd_cpu_gnt", cpu_gnt, w == W_CPU);
      check("rnd_host_gnt", host_gnt, w == W_HOST);
      check("rnd_mem_en", mem_en, w != W_NONE);
      check("rnd_cpu_rvalid", cpu_rvalid, e_cv);
      check("rnd_host_rvalid", host_rvalid, e_hv);
      check("rnd_cpu_rdata", cpu_rdata, e_cd);
      check("rnd_host_rdata", host_rdata, e_hd);
      if (w != W_NONE) begin
        e_we   = (w == W_CPU) ? c_w : h_w;
        e_addr = (w == W_CPU) ? c_a : h_a;
        e_wd   = (w == W_CPU) ? c_d : h_d;
        check("rnd_mem_we", mem_we, e_we);
        check("rnd_mem_addr", mem_addr, e_addr);
        if (e_we) check("rnd_mem_wdata", mem_wdata, e_wd);
      end
      e_cv = 1'b0;
      e_hv = 1'b0;
      if (w == W_CPU) begin
        if (c_w) shadow[c_a] = c_d;
        else begin e_cv = 1'b1; e_cd = shadow[c_a]; end
        c_pend = 1'b0;
      end else if (w == W_HOST) begin
        if (h_w) shadow[h_a] = h_d;
        else begin e_hv = 1'b1; e_hd = shadow[h_a]; end
        h_pend = 1'b0;
      end
      if (w != W_NONE) hist.push_back(w);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
